// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART blocks: register offsets,
// STATUS bit positions, transmitter state encoding and the divisor floor.
package uart_pkg;

   // Word offsets on the data-memory bus.
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_DIVISOR = 2'd2;

   // STATUS register layout.
   localparam int unsigned STATUS_BUSY      = 0;
   localparam int unsigned STATUS_FULL      = 1;
   localparam int unsigned STATUS_EMPTY     = 2;
   localparam int unsigned STATUS_OVERFLOW  = 3;
   localparam int unsigned STATUS_COUNT_LSB = 4;

   // Smallest clocks-per-bit the baud counter accepts.
   localparam logic [15:0] MIN_DIVISOR = 16'd2;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus slice seen by the UART: single-cycle strobes, word
// address, store data and registered load data.
interface uart_tx_mmio_if;
   logic        write_enable;
   logic        read_enable;
   logic [1:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (
      output write_enable, read_enable, address, write_data,
      input  read_data
   );

   modport slave (
      input  write_enable, read_enable, address, write_data,
      output read_data
   );
endinterface

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO. Pointers carry one extra wrap bit so full and empty
// fall out of a plain comparison; a pop frees the slot for a same-cycle push.
module byte_fifo #(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        push_ok, pop_ok;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count    = wr_ptr_q - rd_ptr_q;
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem[rd_ptr_q[AW-1:0]];

   // Advance each pointer by one on an accepted push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
   end

   // Pointer registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents need no reset since the pointers gate them.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. Stores to DATA enqueue bytes, a baud
// FSM shifts them out LSB first. Defining UART_TX_SIM_PRINT_EN echoes every
// accepted byte to the simulator console (simulation only).
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd108
) (
   input  logic           clock,
   input  logic           reset,
   uart_tx_mmio_if.slave  bus,
   output logic           tx,
   output logic           irq_empty
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] div_lat_q, div_lat_d;
   logic [15:0] divisor_q, divisor_d;
   logic        overflow_q, overflow_d;
   logic [31:0] read_data_q, read_data_d;

   logic          data_push, div_write, fifo_pop, fifo_full, fifo_empty, baud_done;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic [31:0]   count_ext, status;
   logic [3:0]    count_sat;
   logic          unused_wdata;

   assign data_push    = bus.write_enable && (bus.address == ADDR_DATA);
   assign div_write    = bus.write_enable && (bus.address == ADDR_DIVISOR);
   assign baud_done    = (cnt_q == div_lat_q - 16'd1);
   assign irq_empty    = fifo_empty && (state_q == IDLE);
   assign bus.read_data = read_data_q;
   assign unused_wdata = ^bus.write_data[31:16];

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (data_push),
      .push_data (bus.write_data[7:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // STATUS image; count field saturates at 15 for deep FIFOs.
   always_comb begin
      count_ext = 32'(fifo_count);
      count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
      status                          = '0;
      status[STATUS_BUSY]             = (state_q != IDLE);
      status[STATUS_FULL]             = fifo_full;
      status[STATUS_EMPTY]            = fifo_empty;
      status[STATUS_OVERFLOW]         = overflow_q;
      status[STATUS_COUNT_LSB +: 4]   = count_sat;
   end

   // Register file: reads see pre-write state; a same-cycle drop keeps overflow set.
   always_comb begin
      divisor_d   = divisor_q;
      overflow_d  = overflow_q;
      read_data_d = read_data_q;
      if (bus.read_enable) begin
         case (bus.address)
            ADDR_STATUS: begin
               read_data_d = status;
               overflow_d  = 1'b0;
            end
            ADDR_DIVISOR: read_data_d = {16'h0, divisor_q};
            default:      read_data_d = '0;
         endcase
      end
      if (data_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
      if (div_write) begin
         divisor_d = (bus.write_data[15:0] < MIN_DIVISOR) ? MIN_DIVISOR : bus.write_data[15:0];
      end
   end

   // Baud FSM next state; the divisor is latched at pop so mid-frame writes wait.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      div_lat_d = div_lat_q;
      fifo_pop  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_rdata;
               div_lat_d = divisor_q;
               cnt_d     = '0;
               bit_d     = '0;
               state_d   = START;
            end
         end
         START: begin
            cnt_d = baud_done ? 16'd0 : cnt_q + 16'd1;
            if (baud_done) state_d = DATA;
         end
         DATA: begin
            cnt_d = baud_done ? 16'd0 : cnt_q + 16'd1;
            if (baud_done) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            cnt_d = baud_done ? 16'd0 : cnt_q + 16'd1;
            if (baud_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level decoded from state so reset forces idle-high asynchronously.
   always_comb begin
      tx = 1'b1;
      if (state_q == START) tx = 1'b0;
      else if (state_q == DATA) tx = shift_q[0];
   end

   // State and register file storage.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         div_lat_q   <= DEFAULT_DIVISOR;
         divisor_q   <= DEFAULT_DIVISOR;
         overflow_q  <= 1'b0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         div_lat_q   <= div_lat_d;
         divisor_q   <= divisor_d;
         overflow_q  <= overflow_d;
         read_data_q <= read_data_d;
      end
   end

`ifdef UART_TX_SIM_PRINT_EN
   logic push_accepted;
   assign push_accepted = data_push && (!fifo_full || fifo_pop);

   // Echo firmware output to the console.
   always_ff @(posedge clock) begin
      if (push_accepted) $write("%c", bus.write_data[7:0]);
   end
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio. The tx line and irq_empty are logged
// every cycle and compared against waveforms computed from frame arithmetic.
module tb_uart_tx_mmio;
   import uart_pkg::*;

   localparam int LOGN = 16384;
   localparam logic [31:0] DEF_DIV = 32'd108;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic tx, irq_empty;
   int   pc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic txlog  [LOGN];
   logic irqlog [LOGN];
   logic [7:0] burst [16];

   uart_tx_mmio_if bus ();

   uart_tx_mmio #(
      .FIFO_DEPTH      (8),
      .DEFAULT_DIVISOR (16'd108)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .tx        (tx),
      .irq_empty (irq_empty)
   );

   always #5 clock = ~clock;

   always @(posedge clock) pc <= pc + 1;

   always @(negedge clock) begin
      if (pc < LOGN) begin
         txlog[pc]  = tx;
         irqlog[pc] = irq_empty;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clock);
      bus.write_enable = 1'b1;
      bus.address      = a;
      bus.write_data   = d;
      @(negedge clock);
      bus.write_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clock);
      bus.read_enable = 1'b1;
      bus.address     = a;
      @(negedge clock);
      bus.read_enable = 1'b0;
      d = bus.read_data;
   endtask

   task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      bus_read(a, rd);
      check(tag, rd, exp);
   endtask

   // Push burst[0..n-1] on consecutive cycles; t0 is the cycle tx first goes low.
   task automatic push_burst(input int n, output int t0);
      @(negedge clock);
      t0 = pc + 2;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clock);
         bus.write_enable = 1'b1;
         bus.address      = ADDR_DATA;
         bus.write_data   = {24'h0, burst[i]};
      end
      @(negedge clock);
      bus.write_enable = 1'b0;
   endtask

   // n back-to-back frames of burst[] starting at t0: 10*div clocks each,
   // one idle clock between, irq_empty only after the last stop bit.
   task automatic check_frames(input string tag, input int t0, input int div, input int n);
      int period, tend, rel, k, r, tx_err, irq_err;
      logic etx, eirq;
      period  = 10 * div + 1;
      tend    = t0 + n * period - 1;
      tx_err  = 0;
      irq_err = 0;
      while (pc <= tend) @(negedge clock);
      for (int c = t0 - 1; c <= tend; c++) begin
         if (c < 0 || c >= LOGN) begin
            tx_err++;
         end else begin
            if (c == t0 - 1) begin
               etx = 1'b1;
            end else begin
               rel = c - t0;
               k   = rel / period;
               r   = rel % period;
               if (r < div) etx = 1'b0;
               else if (r < 9 * div) etx = burst[k][r / div - 1];
               else etx = 1'b1;
            end
            eirq = (c == tend);
            if (txlog[c] !== etx) tx_err++;
            if (c >= t0 && irqlog[c] !== eirq) irq_err++;
         end
      end
      check({tag, "_tx_errs"}, tx_err, 0);
      check({tag, "_irq_errs"}, irq_err, 0);
   endtask

   initial begin
      int t0, div, n, lowc;
      logic [31:0] rd;
      bus.write_enable = 1'b0;
      bus.read_enable  = 1'b0;
      bus.address      = '0;
      bus.write_data   = '0;

      // Reset state.
      repeat (3) @(negedge clock);
      check("rst_tx", tx, 1);
      check("rst_irq", irq_empty, 1);
      check("rst_rdata", bus.read_data, 0);
      reset = 1'b1;
      read_check("rst_status", ADDR_STATUS, 32'h4);
      read_check("rst_divisor", ADDR_DIVISOR, DEF_DIV);
      read_check("data_reads_0", ADDR_DATA, 0);
      read_check("reserved_reads_0", 2'd3, 0);
      bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
      bus_write(2'd3, 32'h0000_0005);
      read_check("status_write_ignored", ADDR_STATUS, 32'h4);
      read_check("reserved_write_ignored", ADDR_DIVISOR, DEF_DIV);

      // 0x41 at the default divisor.
      burst[0] = 8'h41;
      push_burst(1, t0);
      check_frames("f41", t0, 108, 1);
      read_check("f41_idle_status", ADDR_STATUS, 32'h4);

      // Two back-to-back frames at divisor 4.
      bus_write(ADDR_DIVISOR, 32'd4);
      burst[0] = 8'h55;
      burst[1] = 8'hAA;
      push_burst(2, t0);
      check_frames("b2b", t0, 4, 2);

      // Overflow: first byte popped, next 8 fill the FIFO, 10th dropped.
      for (int i = 0; i < 10; i++) burst[i] = 8'($urandom);
      push_burst(10, t0);
      read_check("ovf_status", ADDR_STATUS, 32'h8B);
      read_check("ovf_cleared", ADDR_STATUS, 32'h83);
      check_frames("ovf", t0, 4, 9);

      // Push while full in the pop cycle is accepted.
      bus_write(ADDR_DIVISOR, 32'd2);
      for (int i = 0; i < 10; i++) burst[i] = 8'($urandom);
      push_burst(9, t0);
      while (pc < t0 + 19) @(negedge clock);
      bus_write(ADDR_DATA, {24'h0, burst[9]});
      check_frames("fullpop", t0, 2, 10);
      read_check("fullpop_no_ovf", ADDR_STATUS, 32'h4);

      // Divisor floor and width.
      bus_write(ADDR_DIVISOR, 32'd1);
      read_check("div1_clamped", ADDR_DIVISOR, 32'd2);
      bus_write(ADDR_DIVISOR, 32'h0001_2345);
      read_check("div_16bit", ADDR_DIVISOR, 32'h2345);
      bus_write(ADDR_DIVISOR, 32'd0);
      read_check("div0_clamped", ADDR_DIVISOR, 32'd2);
      burst[0] = 8'($urandom);
      push_burst(1, t0);
      read_check("busy_after_push", ADDR_STATUS, 32'h5);
      check_frames("div2", t0, 2, 1);

      // Simultaneous read and write return the old value.
      @(negedge clock);
      bus.read_enable  = 1'b1;
      bus.write_enable = 1'b1;
      bus.address      = ADDR_DIVISOR;
      bus.write_data   = 32'd7;
      @(negedge clock);
      bus.read_enable  = 1'b0;
      bus.write_enable = 1'b0;
      check("rw_old_value", bus.read_data, 32'd2);
      read_check("rw_new_value", ADDR_DIVISOR, 32'd7);

      // Reset in the middle of data bit 3 (bit 3 forced to 0).
      burst[0] = 8'($urandom) & 8'hF7;
      push_burst(1, t0);
      while (pc < t0 + 4 * 7 + 1) @(negedge clock);
      check("bit3_low", tx, 0);
      reset = 1'b0;
      #1;
      check("async_tx_high", tx, 1);
      check("async_irq", irq_empty, 1);
      check("async_rdata", bus.read_data, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      read_check("post_rst_status", ADDR_STATUS, 32'h4);
      read_check("post_rst_divisor", ADDR_DIVISOR, DEF_DIV);
      lowc = 0;
      repeat (200) begin
         @(negedge clock);
         if (tx !== 1'b1) lowc++;
      end
      check("no_residual_tx", lowc, 0);

      // Random divisors and burst lengths.
      for (int it = 0; it < 4; it++) begin
         div = $urandom_range(2, 5);
         n   = $urandom_range(1, 9);
         for (int i = 0; i < n; i++) burst[i] = 8'($urandom);
         bus_write(ADDR_DIVISOR, 32'(div));
         push_burst(n, t0);
         check_frames("rand", t0, div, n);
      end
      read_check("final_status", ADDR_STATUS, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
